// File: rtl/lcd_bus_writer.sv
// LCD bus writer: sends one byte per handshake as one (8-bit) or two (4-bit) timed E strobes.
// Optional LCD_LONG_CMD_EN: clear/home commands (0x01/0x02) get the T_GAP_LONG post-byte gap.
module lcd_bus_writer #(
    parameter int BUS_WIDTH  = 4,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 12,
    parameter int T_HOLD     = 1,
    parameter int T_GAP_NIB  = 50,
    parameter int T_GAP_CMD  = 2000,
    parameter int T_GAP_LONG = 82000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 wr_rs,
    input  logic [7:0]           wr_data,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_E,
    output logic [BUS_WIDTH-1:0] LCD_D,
    output logic                 busy
);

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("lcd_bus_writer: BUS_WIDTH must be 4 or 8");
    end
    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_GAP_NIB < 1 || T_GAP_CMD < 1 ||
        T_GAP_LONG < 1 || T_SETUP >= 2**20 || T_PULSE >= 2**20 || T_HOLD >= 2**20 ||
        T_GAP_NIB >= 2**20 || T_GAP_CMD >= 2**20 || T_GAP_LONG >= 2**20) begin : g_bad_timing
        $error("lcd_bus_writer: timing parameters must be in 1 .. 2^20-1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP_NIB, S_GAP_CMD
    } state_t;

    // Counters are loaded with N-1 so a state lasts exactly N cycles.
    localparam logic [19:0] LD_SETUP   = 20'(T_SETUP - 1);
    localparam logic [19:0] LD_PULSE   = 20'(T_PULSE - 1);
    localparam logic [19:0] LD_HOLD    = 20'(T_HOLD - 1);
    localparam logic [19:0] LD_GAP_NIB = 20'(T_GAP_NIB - 1);
    localparam logic [19:0] LD_GAP_CMD = 20'(T_GAP_CMD - 1);

    state_t                 state;
    logic [19:0]            cnt;
    logic                   second_nib;
    logic [BUS_WIDTH-1:0]   lo_q;
    logic [19:0]            gap_load;

    // In 4-bit mode the first beat is the high nibble; in 8-bit mode the whole byte.
    function automatic logic [BUS_WIDTH-1:0] first_beat(input logic [7:0] d);
        return BUS_WIDTH'(d >> (8 - BUS_WIDTH));
    endfunction

`ifdef LCD_LONG_CMD_EN
    localparam logic [19:0] LD_GAP_LONG = 20'(T_GAP_LONG - 1);
    logic long_q;
    assign gap_load = long_q ? LD_GAP_LONG : LD_GAP_CMD;
`else
    assign gap_load = LD_GAP_CMD;
`endif

    assign LCD_RW = 1'b0;
    assign busy   = ~wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            second_nib <= 1'b0;
            lo_q       <= '0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_D      <= '0;
            wr_ready   <= 1'b1;
`ifdef LCD_LONG_CMD_EN
            long_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_valid && wr_ready) begin
                        lo_q     <= BUS_WIDTH'(wr_data);
                        LCD_RS   <= wr_rs;
                        LCD_D    <= first_beat(wr_data);
                        wr_ready <= 1'b0;
                        cnt      <= LD_SETUP;
                        state    <= S_SETUP;
`ifdef LCD_LONG_CMD_EN
                        long_q   <= !wr_rs && (wr_data == 8'h01 || wr_data == 8'h02);
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b1;
                        cnt   <= LD_PULSE;
                        state <= S_PULSE;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b0;
                        cnt   <= LD_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        if (BUS_WIDTH == 4 && !second_nib) begin
                            second_nib <= 1'b1;
                            cnt        <= LD_GAP_NIB;
                            state      <= S_GAP_NIB;
                        end else begin
                            cnt   <= gap_load;
                            state <= S_GAP_CMD;
                        end
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_GAP_NIB: begin
                    if (cnt == '0) begin
                        LCD_D <= lo_q;
                        cnt   <= LD_SETUP;
                        state <= S_SETUP;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_GAP_CMD: begin
                    if (cnt == '0) begin
                        second_nib <= 1'b0;
                        wr_ready   <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    LCD_E    <= 1'b0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: default-timing vectors (4/8-bit), reset abort, randomized run vs timeline model.
module tb_lcd_bus_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       t_rs;
    logic [7:0] t_data;

    logic       a_valid, a_ready, a_RS, a_RW, a_E, a_busy;
    logic [3:0] a_D;
    logic       w_valid, w_ready, w_RS, w_RW, w_E, w_busy;
    logic [7:0] w_D;
    logic       f_valid, f_rs, f_ready, f_RS, f_RW, f_E, f_busy;
    logic [7:0] f_data;
    logic [3:0] f_D;

    lcd_bus_writer u_a (
        .clk(clk), .reset(rst), .wr_valid(a_valid), .wr_ready(a_ready), .wr_rs(t_rs),
        .wr_data(t_data), .LCD_RS(a_RS), .LCD_RW(a_RW), .LCD_E(a_E), .LCD_D(a_D), .busy(a_busy)
    );

    lcd_bus_writer #(.BUS_WIDTH(8)) u_w (
        .clk(clk), .reset(rst), .wr_valid(w_valid), .wr_ready(w_ready), .wr_rs(t_rs),
        .wr_data(t_data), .LCD_RS(w_RS), .LCD_RW(w_RW), .LCD_E(w_E), .LCD_D(w_D), .busy(w_busy)
    );

    localparam int FS = 2, FP = 3, FH = 1, FGN = 2, FGC = 4, FGL = 7;
    localparam int FQ = FS + FP + FH + FGN;
`ifdef LCD_LONG_CMD_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    lcd_bus_writer #(.T_SETUP(FS), .T_PULSE(FP), .T_HOLD(FH), .T_GAP_NIB(FGN),
                     .T_GAP_CMD(FGC), .T_GAP_LONG(FGL)) u_f (
        .clk(clk), .reset(rst), .wr_valid(f_valid), .wr_ready(f_ready), .wr_rs(f_rs),
        .wr_data(f_data), .LCD_RS(f_RS), .LCD_RW(f_RW), .LCD_E(f_E), .LCD_D(f_D), .busy(f_busy)
    );

    logic       sel;
    logic       m_E, m_RS, m_RW, m_ready, m_busy;
    logic [7:0] m_D;
    always_comb begin
        if (sel) begin
            m_E = w_E; m_RS = w_RS; m_RW = w_RW; m_ready = w_ready; m_busy = w_busy; m_D = w_D;
        end else begin
            m_E = a_E; m_RS = a_RS; m_RW = a_RW; m_ready = a_ready; m_busy = a_busy;
            m_D = {4'h0, a_D};
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic       s;
        logic       rs;
        logic [7:0] d;
        int         e1;
        int         e2;
        int         enp;
        int         elow;
    } vec_t;

    // Offers one byte, then observes E pulses, bus values and ready-low time (bounded).
    task automatic xfer(input logic s, input logic rs, input logic [7:0] d,
                        output int np, output int d1, output int d2, output int w1,
                        output int sp, output int low, output int rs_bad, output int dchg,
                        output int side_bad);
        int  t1;
        logic prev;
        np = 0; d1 = -1; d2 = -1; w1 = 0; sp = -1; low = -1; rs_bad = 0; dchg = 0;
        side_bad = 0; t1 = 0; prev = 1'b0;
        @(negedge clk);
        sel = s; t_rs = rs; t_data = d;
        if (s) w_valid = 1'b1; else a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; w_valid = 1'b0; t_data = ~d; t_rs = ~rs;
        for (int k = 0; k < 5000; k++) begin
            if (k > 0) @(negedge clk);
            if (m_ready) begin
                low = k;
                break;
            end
            if (m_E && !prev) begin
                np++;
                if (np == 1) begin d1 = int'(m_D); t1 = k; end
                else if (np == 2) begin d2 = int'(m_D); sp = k - t1; end
            end
            if (m_E && np == 1) w1++;
            if (m_E && int'(m_D) != ((np <= 1) ? d1 : d2)) dchg++;
            if (m_RS != rs) rs_bad++;
            if (m_RW != 1'b0 || m_busy != !m_ready) side_bad++;
            prev = m_E;
        end
        if (low < 0) low = 5000;
    endtask

    vec_t vecs[$];
    int   np, d1, d2, w1, sp, low, rs_bad, dchg, side_bad;

    // Randomized-run model state: timeline offset since accept, current byte.
    bit         busy_m;
    int         k_m, L_m, accepted;
    logic [3:0] hi_m, last_d;
    logic       rs_m, exp_e;
    logic [3:0] exp_d;

    initial begin
        rst = 1'b1; sel = 1'b0; t_rs = 1'b0; t_data = 8'h00;
        a_valid = 1'b0; w_valid = 1'b0; f_valid = 1'b0; f_rs = 1'b0; f_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_ready", int'(a_ready), 1);
        chk("rst_a_e", int'(a_E), 0);
        chk("rst_a_rs", int'(a_RS), 0);
        chk("rst_a_d", int'(a_D), 0);
        chk("rst_a_rw", int'(a_RW), 0);
        chk("rst_a_busy", int'(a_busy), 0);
        chk("rst_w_d", int'(w_D), 0);
        chk("rst_f_ready", int'(f_ready), 1);

        vecs.push_back('{1'b0, 1'b0, 8'h28, 2, 8, 2, 2080});
        vecs.push_back('{1'b0, 1'b1, 8'h41, 4, 1, 2, 2080});
        vecs.push_back('{1'b1, 1'b0, 8'h38, 8'h38, -1, 1, 2015});
        vecs.push_back('{1'b1, 1'b1, 8'hA5, 8'hA5, -1, 1, 2015});
        vecs.push_back('{1'b0, 1'b1, 8'h01, 0, 1, 2, 2080});
`ifndef LCD_LONG_CMD_EN
        vecs.push_back('{1'b0, 1'b0, 8'h01, 0, 1, 2, 2080});
`endif
        foreach (vecs[i]) begin
            xfer(vecs[i].s, vecs[i].rs, vecs[i].d, np, d1, d2, w1, sp, low, rs_bad, dchg, side_bad);
            chk($sformatf("v%0d_npulse", i), np, vecs[i].enp);
            chk($sformatf("v%0d_beat1", i), d1, vecs[i].e1);
            chk($sformatf("v%0d_beat2", i), d2, vecs[i].e2);
            if (vecs[i].enp == 2) chk($sformatf("v%0d_spacing", i), sp, 65);
            chk($sformatf("v%0d_width", i), w1, 12);
            chk($sformatf("v%0d_ready_low", i), low, vecs[i].elow);
            chk($sformatf("v%0d_rs_stable", i), rs_bad, 0);
            chk($sformatf("v%0d_d_stable", i), dchg, 0);
            chk($sformatf("v%0d_rw_busy", i), side_bad, 0);
        end

        // Abort a byte with reset in the 5th PULSE cycle.
        @(negedge clk);
        sel = 1'b0; t_rs = 1'b1; t_data = 8'hFF; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 100 && !a_E; k++) @(negedge clk);
        chk("abort_e_rise", int'(a_E), 1);
        repeat (4) @(negedge clk);
        chk("abort_e_pulse5", int'(a_E), 1);
        chk("abort_rs_before", int'(a_RS), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_e", int'(a_E), 0);
        chk("abort_rs", int'(a_RS), 0);
        chk("abort_d", int'(a_D), 0);
        chk("abort_rw", int'(a_RW), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(a_ready), 1);
        chk("abort_e_after", int'(a_E), 0);
        xfer(1'b0, 1'b0, 8'h0C, np, d1, d2, w1, sp, low, rs_bad, dchg, side_bad);
        chk("post_npulse", np, 2);
        chk("post_beat1", d1, 0);
        chk("post_beat2", d2, 12);
        chk("post_ready_low", low, 2080);

        // Randomized run on short-timing instance; second half holds wr_valid high.
        busy_m = 1'b0; k_m = 0; L_m = 0; accepted = 0; hi_m = 4'h0; last_d = 4'h0; rs_m = 1'b0;
        for (int c = 0; c < 3000 && bad <= 20; c++) begin
            @(negedge clk);
            exp_e = busy_m && ((k_m >= FS && k_m < FS + FP) ||
                               (k_m >= FQ + FS && k_m < FQ + FS + FP));
            exp_d = (busy_m && k_m < FQ) ? hi_m : last_d;
            chk("f_ready", int'(f_ready), int'(!busy_m));
            chk("f_e", int'(f_E), int'(exp_e));
            chk("f_rs", int'(f_RS), int'(rs_m));
            chk("f_d", int'(f_D), int'(exp_d));
            chk("f_busy", int'(f_busy), int'(busy_m));
            f_valid = (c >= 1500) ? 1'b1 : ($urandom_range(0, 3) == 0);
            f_rs    = 1'($urandom_range(0, 1));
            f_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            if (busy_m) begin
                k_m++;
                if (k_m == L_m) busy_m = 1'b0;
            end else if (f_valid) begin
                busy_m = 1'b1; k_m = 0; accepted++;
                hi_m = f_data[7:4]; last_d = f_data[3:0]; rs_m = f_rs;
                L_m = 2 * (FS + FP + FH) + FGN +
                      ((LONG_EN && !f_rs && (f_data == 8'h01 || f_data == 8'h02)) ? FGL : FGC);
            end
        end
        f_valid = 1'b0;
        if (accepted < 50) chk("f_accept_count", accepted, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_writer.md
LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 Parameter BUS_WIDTH, default 4, LCD data bus width; legal values 4 or 8 only.
REQ-002 Parameter T_SETUP, default 2, clock cycles that RS/D are stable before LCD_E rises.
REQ-003 Parameter T_PULSE, default 12, clock cycles LCD_E is high.
REQ-004 Parameter T_HOLD, default 1, clock cycles RS/D are held after LCD_E falls.
REQ-005 Parameter T_GAP_NIB, default 50, idle cycles between the two nibbles of one byte (4-bit mode).
REQ-006 Parameter T_GAP_CMD, default 2000, idle cycles after a complete byte before the next byte is accepted.
REQ-007 Parameter T_GAP_LONG, default 82000, post-byte gap for long commands (see Configuration).
REQ-008 clk  input  1  system clock; all state changes on the rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 wr_valid  input  1  a byte is offered for transfer.
REQ-011 wr_ready  output  1  block can accept a byte this cycle.
REQ-012 wr_rs  input  1  register select for the offered byte: 0 = command, 1 = character data.
REQ-013 wr_data  input  8  byte to transfer.
REQ-014 LCD_RS  output  1  register select to panel.
REQ-015 LCD_RW  output  1  read/write to panel, constant 0.
REQ-016 LCD_E  output  1  enable strobe to panel.
REQ-017 LCD_D  output  BUS_WIDTH  data bus to panel; in 4-bit mode maps to SF_D11..SF_D8 at top level.
REQ-018 busy  output  1  inverse of wr_ready.

Function
REQ-019 A byte SHALL be accepted on a rising edge where wr_valid and wr_ready are both 1; wr_rs/wr_data are captured into internal registers at that edge.
REQ-020 wr_ready SHALL be 1 only in state IDLE; wr_valid while not ready SHALL be ignored with no side effect.
REQ-021 FSM states: IDLE, SETUP, PULSE, HOLD, GAP_NIB, GAP_CMD; each timed state lasts exactly its parameter in cycles via a 20-bit down-counter.
REQ-022 Transitions: IDLE->SETUP on accept; SETUP->PULSE; PULSE->HOLD; HOLD->GAP_NIB if first nibble in 4-bit mode, else HOLD->GAP_CMD; GAP_NIB->SETUP (second nibble); GAP_CMD->IDLE.
REQ-023 LCD_RS and LCD_D SHALL change only on entry to SETUP and remain stable through SETUP, PULSE, HOLD and the following gap.
REQ-024 4-bit mode: first nibble = wr_data[7:4], second = wr_data[3:0]; 8-bit mode: LCD_D = wr_data, one pulse per byte.
REQ-025 LCD_E SHALL be 1 exactly in state PULSE, registered, glitch-free.
REQ-026 Accept-to-ready latency (4-bit) SHALL be 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP_NIB+gap cycles; (8-bit) T_SETUP+T_PULSE+T_HOLD+gap, where gap is T_GAP_CMD or T_GAP_LONG.
REQ-027 wr_valid held high at the edge GAP_CMD->IDLE SHALL not be accepted that edge; acceptance occurs on the first edge where wr_ready is already 1.
REQ-028 Parameter values SHALL be >= 1 and < 2^20; a value of 1 gives a one-cycle state.

Reset
REQ-029 reset asserted SHALL immediately force state IDLE, LCD_E=0, LCD_RS=0, LCD_D=0, LCD_RW=0, counter=0, nibble flag=0, wr_ready=1 after deassertion.
REQ-030 reset asserted mid-transfer (including during PULSE) SHALL abort the byte; LCD_E drops asynchronously; no partial nibble resumes.

Configuration
REQ-031 Macro LCD_LONG_CMD_EN defined: a command byte (wr_rs=0) equal to 0x01 or 0x02 SHALL use T_GAP_LONG as its post-byte gap; all other bytes use T_GAP_CMD.
REQ-032 Macro LCD_LONG_CMD_EN undefined: every byte uses T_GAP_CMD; T_GAP_LONG is unused and no comparison logic is synthesised.

Verification
REQ-033 Defaults, write rs=0 data 0x28 -> LCD_D=0x2 during first 12-cycle E pulse, 0x8 during second, LCD_RS=0, pulses 65 cycles apart rising-edge to rising-edge, wr_ready low for 2080 cycles.
REQ-034 Defaults, write rs=1 data 0x41 -> LCD_RS=1 throughout, nibbles 0x4 then 0x1, wr_ready low 2080 cycles (long gap never applies to data).
REQ-035 LCD_LONG_CMD_EN defined, write rs=0 data 0x01 -> wr_ready low 82080 cycles; same with macro undefined -> 2080 cycles.
REQ-036 BUS_WIDTH=8, write rs=0 data 0x38 -> single E pulse with LCD_D=0x38, wr_ready low 2015 cycles.
REQ-037 Assert reset during 5th cycle of PULSE -> LCD_E=0 same cycle, all outputs 0; after release next byte 0x0C transfers with correct nibbles 0x0, 0xC.
REQ-038 Hold wr_valid=1 with changing wr_data during busy -> only the byte present at each accept edge is sent, none lost or duplicated.
